pc_unit_ras: RTL and testbench

//  Fetch-address generator for the RV32 core: holds the program counter, selects the next PC
//  (sequential / JAL / JALR / conditional branch), and detects the halt address and misaligned targets.

---
 rtl/pc_unit_ras.sv | 138 +++++++++++++
 tb/tb_pc_unit_ras.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Fetch-address generator: program counter, next-PC select, halt/fault state machine
// and a circular return-address stack.
module pc_unit_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h5c,
  parameter logic [XLEN-1:0] HALT_ADDR    = 32'h94,
  parameter bit              HALT_EN      = 1'b1,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      BranchNoCondition,
  input  logic            BranchCondition,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] rs1Data,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] pc_plus4, target;
  logic            jump_sel, halt_sel, misaligned, ras_active;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   sp_q, sp_d, top_idx, ras_wa;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ras_we;

  // Next-PC selection: jumps/branches first, then the halt self-loop, then sequential.
  always_comb begin
    pc_plus4 = pc_q + XLEN'(4);
    target   = pc_plus4;
    jump_sel = 1'b0;
    if (BranchNoCondition == 2'b01) begin
      target   = pc_q + offset;
      jump_sel = 1'b1;
    end else if (BranchNoCondition == 2'b10) begin
      target   = (rs1Data + offset) & ~XLEN'(1);
      jump_sel = 1'b1;
    end else if (BranchCondition) begin
      target   = pc_q + offset;
      jump_sel = 1'b1;
    end
    halt_sel   = !jump_sel && HALT_EN && (pc_q == HALT_ADDR);
    misaligned = jump_sel && target[1];
    next_pc    = jump_sel ? target : (halt_sel ? pc_q : pc_plus4);
  end

  // RUN/HALT/FAULT next state; stall or a terminal state holds everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    if (!stall && state_q == StRun) begin
      if (misaligned) begin
        state_d    = StFault;
        fault_pc_d = pc_q;
      end else begin
        pc_d = next_pc;
        if (halt_sel) state_d = StHalt;
      end
    end
    ras_active = !stall && (state_q == StRun) && !misaligned;
  end

  // RAS pointer/count update; sp_q is the next free slot, so the top is sp_q-1.
  always_comb begin
    top_idx = sp_q - PW'(1);
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ras_we  = 1'b0;
    ras_wa  = sp_q;
    if (ras_active) begin
      if (ras_push && ras_pop && cnt_q != '0) begin
        ras_we = 1'b1;
        ras_wa = top_idx;
      end else if (ras_push) begin
        // When full, the slot at sp_q holds the oldest entry and is overwritten.
        ras_we = 1'b1;
        sp_d   = sp_q + PW'(1);
        if (cnt_q != DepthC) cnt_d = cnt_q + CW'(1);
      end else if (ras_pop && cnt_q != '0) begin
        sp_d  = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State, PC, fault capture and RAS pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_VECTOR;
      fault_pc_q <= '0;
      sp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAS storage; contents are meaningless while count is zero, so no reset needed.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_wa] <= pc_plus4;
  end

  // Registered outputs and occupancy flags.
  always_comb begin
    pc        = pc_q;
    fault_pc  = fault_pc_q;
    halted    = (state_q == StHalt);
    fault     = (state_q == StFault);
    ras_empty = (cnt_q == '0);
    ras_full  = (cnt_q == DepthC);
    ras_top   = ras_empty ? '0 : ras_mem[top_idx];
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: expected post-edge state is queued when stimulus is
// driven and compared one edge later.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        reset, stall, BranchCondition, ras_push, ras_pop;
  logic [1:0]  BranchNoCondition;
  logic [31:0] offset, rs1Data;
  logic [31:0] pc, next_pc, fault_pc, ras_top;
  logic        halted, fault, ras_empty, ras_full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
  } exp_t;

  exp_t sb[$];

  pc_unit_ras dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .BranchNoCondition (BranchNoCondition),
    .BranchCondition   (BranchCondition),
    .offset            (offset),
    .rs1Data           (rs1Data),
    .ras_push          (ras_push),
    .ras_pop           (ras_pop),
    .pc                (pc),
    .next_pc           (next_pc),
    .halted            (halted),
    .fault             (fault),
    .fault_pc          (fault_pc),
    .ras_top           (ras_top),
    .ras_empty         (ras_empty),
    .ras_full          (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the coming edge.
  task automatic drive(input logic rst, input logic stl, input logic [1:0] bnc, input logic bc,
                       input logic [31:0] off, input logic [31:0] rs1, input logic psh,
                       input logic pop, input logic [31:0] e_pc, input logic e_h,
                       input logic e_f, input logic [31:0] e_fpc, input logic [31:0] e_top,
                       input logic e_emp, input logic e_full);
    exp_t e;
    reset = rst; stall = stl; BranchNoCondition = bnc; BranchCondition = bc;
    offset = off; rs1Data = rs1; ras_push = psh; ras_pop = pop;
    e.pc = e_pc; e.halted = e_h; e.fault = e_f; e.fault_pc = e_fpc;
    e.ras_top = e_top; e.ras_empty = e_emp; e.ras_full = e_full;
    sb.push_back(e);
  endtask

  // Advance one edge, then pop the scoreboard and compare every observable.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0)
    else begin
      bad++;
      $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".halted"}, 32'(halted), 32'(e.halted));
      chk({tag, ".fault"}, 32'(fault), 32'(e.fault));
      chk({tag, ".fault_pc"}, fault_pc, e.fault_pc);
      chk({tag, ".ras_top"}, ras_top, e.ras_top);
      chk({tag, ".ras_empty"}, 32'(ras_empty), 32'(e.ras_empty));
      chk({tag, ".ras_full"}, 32'(ras_full), 32'(e.ras_full));
    end
  endtask

  // Shorthands: plain step (no stall, no RAS) and reset step.
  task automatic step(input logic [1:0] bnc, input logic bc, input logic [31:0] off,
                      input logic [31:0] rs1, input logic [31:0] e_pc, input logic e_h,
                      input logic e_f, input logic [31:0] e_fpc, input string tag);
    drive(0, 0, bnc, bc, off, rs1, 0, 0, e_pc, e_h, e_f, e_fpc, 0, 1, 0);
    tick(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1, 0, 2'b01, 1, 32'h2, 32'h0, 1, 0, 32'h5c, 0, 0, 0, 0, 1, 0);
    tick(tag);
  endtask

  initial begin
    // 1: reset and sequential fetch; BNC=11 behaves as no jump
    do_reset("rst");
    step(2'b00, 0, 32'h100, 0, 32'h60, 0, 0, 0, "seq1");
    step(2'b00, 0, 32'h100, 0, 32'h64, 0, 0, 0, "seq2");
    step(2'b11, 0, 32'h100, 0, 32'h68, 0, 0, 0, "seq3_bnc11");

    // 2: JALR clears bit0; misaligned JALR target faults and freezes
    do_reset("rst2");
    step(2'b01, 0, 32'h24, 0, 32'h80, 0, 0, 0, "jal80");
    step(2'b10, 0, 32'h10, 32'h101, 32'h110, 0, 0, 0, "jalr110");
    do_reset("rst2b");
    step(2'b01, 0, 32'h24, 0, 32'h80, 0, 0, 0, "jal80b");
    step(2'b10, 0, 32'h12, 32'h101, 32'h80, 0, 1, 32'h80, "jalr_mis");
    drive(0, 0, 2'b01, 0, 32'h8, 0, 1, 0, 32'h80, 0, 1, 32'h80, 0, 1, 0);
    tick("fault_hold1");
    step(2'b00, 0, 0, 0, 32'h80, 0, 1, 32'h80, "fault_hold2");
    do_reset("rst_clr_fault");

    // 3: halt self-loop ignores inputs; branch at HALT_ADDR escapes
    step(2'b01, 0, 32'h34, 0, 32'h90, 0, 0, 0, "jal90");
    step(2'b00, 0, 0, 0, 32'h94, 0, 0, 0, "walk94");
    step(2'b00, 0, 0, 0, 32'h94, 1, 0, 0, "halt");
    for (int i = 0; i < 10; i++) step(2'(i % 3), 1, 32'h8, 0, 32'h94, 1, 0, 0, "halt_hold");
    do_reset("rst3");
    step(2'b01, 0, 32'h38, 0, 32'h94, 0, 0, 0, "jal94");
    step(2'b00, 1, 32'h10, 0, 32'ha4, 0, 0, 0, "br_at_halt");
    step(2'b00, 0, 0, 0, 32'ha8, 0, 0, 0, "after_br");

    // 4: stall freezes PC and RAS
    do_reset("rst4");
    step(2'b01, 0, 32'h10, 0, 32'h6c, 0, 0, 0, "jal6c");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h70, 0, 0, 0, 32'h70, 0, 0);
    tick("push70");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2'b01, 0, 32'h20, 0, 1, 0, 32'h70, 0, 0, 0, 32'h70, 0, 0);
      tick("stall");
    end
    drive(0, 0, 2'b01, 0, 32'h20, 0, 0, 0, 32'h90, 0, 0, 0, 32'h70, 0, 0);
    tick("release");

    // 5: overflow overwrites oldest, underflow is a no-op
    do_reset("rst5");
    step(2'b00, 0, 0, 0, 32'h60, 0, 0, 0, "to60");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h64, 0, 0, 0, 32'h64, 0, 0); tick("push1");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h68, 0, 0, 0, 32'h68, 0, 0); tick("push2");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h6c, 0, 0, 0, 32'h6c, 0, 0); tick("push3");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h70, 0, 0, 0, 32'h70, 0, 1); tick("push4");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h74, 0, 0, 0, 32'h74, 0, 1); tick("push5");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h78, 0, 0, 0, 32'h70, 0, 0); tick("pop1");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h7c, 0, 0, 0, 32'h6c, 0, 0); tick("pop2");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 32'h68, 0, 0); tick("pop3");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h84, 0, 0, 0, 32'h0, 1, 0); tick("pop4");
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h88, 0, 0, 0, 32'h0, 1, 0); tick("pop5_noop");

    // 6: push+pop replaces top; reset empties the stack
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h8c, 0, 0, 0, 32'h8c, 0, 0); tick("push_a");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h90, 0, 0, 0, 32'h90, 0, 0); tick("push_b");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 1, 32'h94, 0, 0, 0, 32'h94, 0, 0); tick("pushpop");
    drive(0, 0, 2'b00, 1, 32'h8, 0, 0, 1, 32'h9c, 0, 0, 0, 32'h8c, 0, 0); tick("pop_after");
    drive(0, 0, 2'b00, 0, 0, 0, 1, 0, 32'ha0, 0, 0, 0, 32'ha0, 0, 0); tick("push_c");
    do_reset("rst6");
    step(2'b00, 0, 0, 0, 32'h60, 0, 0, 0, "post_rst6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
